quadrilatero_reg_access_scheduler: RTL

Per-matrix-register access scheduler that enforces program-ordered read/write access to one register of the matrix register file. The dispatcher pushes one access token per instruction: instruction id, read-needed and write-needed flags. Execution units request reads or writes tagged with their instruction id. Grants go only to the instruction at the head of the token FIFO, and the head retires once all of its declared accesses have completed. One instance exists per matrix register (N_REGS instances); its `full_o` feeds the dispatcher's `rw_queue_full_i` bit.

---
 rtl/quadrilatero_reg_access_scheduler.sv | 138 +++++++++++++
 1 files changed

// File: rtl/quadrilatero_reg_access_scheduler.sv
// Program-ordered access scheduler for one matrix register.
// The dispatcher pushes one token per instruction {id, read-needed, write-needed}.
// Execution units get a grant only when they request the id of the oldest
// token. That token retires on the edge where its last pending access completes.
module quadrilatero_reg_access_scheduler #(
    parameter int DEPTH          = 4,  // power of 2, >= 2
    parameter int NUM_EXEC_UNITS = 3,
    parameter int ID_WIDTH       = 4
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic                                     push_i,
    input  logic                                     push_rvalid_i,
    input  logic                                     push_wready_i,
    input  logic [ID_WIDTH-1:0]                      push_id_i,
    output logic                                     full_o,
    output logic                                     empty_o,
    output logic [$clog2(DEPTH):0]                   count_o,
    output logic                                     overflow_o,
    input  logic [NUM_EXEC_UNITS-1:0]                req_read_i,
    input  logic [NUM_EXEC_UNITS-1:0]                req_write_i,
    input  logic [NUM_EXEC_UNITS-1:0][ID_WIDTH-1:0]  req_id_i,
    output logic [NUM_EXEC_UNITS-1:0]                gnt_read_o,
    output logic [NUM_EXEC_UNITS-1:0]                gnt_write_o,
    input  logic [NUM_EXEC_UNITS-1:0]                rd_done_i,
    input  logic [NUM_EXEC_UNITS-1:0]                wr_done_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Token storage
    logic [ID_WIDTH-1:0] r_id    [DEPTH];
    logic                r_rpend [DEPTH];
    logic                r_wpend [DEPTH];

    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic                      w_full;
    logic                      w_empty;
    logic                      w_push_acc;
    logic                      w_pop;
    logic                      w_rd_clr;
    logic                      w_wr_clr;
    logic [ID_WIDTH-1:0]       w_head_id;
    logic                      w_head_rpend;
    logic                      w_head_wpend;
    logic [NUM_EXEC_UNITS-1:0] w_hit_r;
    logic [NUM_EXEC_UNITS-1:0] w_hit_w;
    logic [NUM_EXEC_UNITS-1:0] w_gnt_r;
    logic [NUM_EXEC_UNITS-1:0] w_gnt_w;
    logic                      w_found_r;
    logic                      w_found_w;

    assign w_full       = (r_count == FULL_COUNT);
    assign w_empty      = (r_count == '0);
    assign w_head_id    = r_id[r_rd_ptr];
    assign w_head_rpend = r_rpend[r_rd_ptr];
    assign w_head_wpend = r_wpend[r_rd_ptr];

    // Tokens that need neither access carry no ordering information and are dropped.
    assign w_push_acc = push_i & ~w_full & (push_rvalid_i | push_wready_i);

    // Match every unit's request against the head token, then pick the lowest-index hit.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
        w_hit_r   = '0;
        w_hit_w   = '0;
        w_gnt_r   = '0;
        w_gnt_w   = '0;
        w_found_r = 1'b0;
        w_found_w = 1'b0;
        for (int u = 0; u < NUM_EXEC_UNITS; u++) begin
            w_hit_r[u] = ~w_empty & w_head_rpend & req_read_i[u]  & (req_id_i[u] == w_head_id);
            w_hit_w[u] = ~w_empty & w_head_wpend & req_write_i[u] & (req_id_i[u] == w_head_id);
            if (w_hit_r[u] && !w_found_r) begin
                w_gnt_r[u] = 1'b1;
                w_found_r  = 1'b1;
            end
            if (w_hit_w[u] && !w_found_w) begin
                w_gnt_w[u] = 1'b1;
                w_found_w  = 1'b1;
            end
        end
    end

    // A done only counts from the unit currently holding the matching grant.
    assign w_rd_clr = |(rd_done_i & w_gnt_r);
    assign w_wr_clr = |(wr_done_i & w_gnt_w);

    // The head retires on the edge where no access remains outstanding.
    assign w_pop = ~w_empty & (~w_head_rpend | w_rd_clr) & (~w_head_wpend | w_wr_clr);

    // Pointers, occupancy and sticky overflow; reset discards all tokens at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            if (w_push_acc) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)      r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push_acc, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (push_i && w_full) r_overflow <= 1'b1;
        end
    end

    // Entry writes: clear completed flags on the head, fill the tail on accepted push.
    // NOTE: entry storage has no reset; the empty flag from the reset count masks stale contents.
    always_ff @(posedge clk_i) begin
        // The head (non-empty) and the tail (non-full) can never alias here.
        if (w_rd_clr) r_rpend[r_rd_ptr] <= 1'b0;
        if (w_wr_clr) r_wpend[r_rd_ptr] <= 1'b0;
        if (w_push_acc) begin
            r_id[r_wr_ptr]    <= push_id_i;
            r_rpend[r_wr_ptr] <= push_rvalid_i;
            r_wpend[r_wr_ptr] <= push_wready_i;
        end
    end

    assign full_o      = w_full;
    assign empty_o     = w_empty;
    assign count_o     = r_count;
    assign overflow_o  = r_overflow;
    assign gnt_read_o  = w_gnt_r;
    assign gnt_write_o = w_gnt_w;

endmodule
